spi_slave_os: RTL

SPI slave (responder) that oversamples the external sclk, cs_n and mosi pins in the system clk domain. It pairs with the team's SPI master. It presents received words on a parallel rx port with a one-cycle valid pulse, and takes transmit words through a single-entry holding register with a ready/load handshake. Supports full duplex and back-to-back words within one cs_n frame.

---
 rtl/spi_slave_os.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_os.sv
`timescale 1ns/1ps
// SPI slave that oversamples sclk/cs_n/mosi in the clk domain.
// Parallel rx word with valid pulse; single-entry tx holding register with ready/load handshake.
module spi_slave_os #(
    parameter int SPI_MODE    = 1,
    parameter int SPI_TRF_BIT = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   cs_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    input  logic [SPI_TRF_BIT-1:0] tx_data,
    input  logic                   tx_load,
    output logic                   tx_ready,
    output logic [SPI_TRF_BIT-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   tx_underrun
);

    localparam int               CNT_W          = $clog2(SPI_TRF_BIT);
    localparam logic [CNT_W-1:0] LAST_BIT       = CNT_W'(SPI_TRF_BIT - 1);
    localparam bit               CPHA           = (SPI_MODE % 2) != 0;
    localparam bit               SAMPLE_ON_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic [SPI_TRF_BIT-1:0] tx_hold;
    logic [SPI_TRF_BIT-1:0] tx_shift;
    logic [SPI_TRF_BIT-2:0] rx_shift;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   word_done;
    logic                   word_start;
    logic [SPI_TRF_BIT-1:0] tx_word;

    // cs_n chain resets low so a frame already in progress at reset release
    // never produces a falling edge; only a fresh cs_n fall opens a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        cs_s        = cs_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_d;
        sclk_fall   = ~sclk_s & sclk_d;
        sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
        shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
        cs_fall     = ~cs_s & cs_d;
        cs_rise     = cs_s & ~cs_d;
        word_done   = (state == ACTIVE) && sample_edge && (bit_cnt == LAST_BIT);
        word_start  = ((state == IDLE) && cs_fall) ||
                      ((state == ACTIVE) && word_done && !cs_rise);
        tx_word     = tx_ready ? '0 : tx_hold;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            tx_hold     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ACTIVE;
                        busy    <= 1'b1;
                        miso_oe <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (word_done) begin
                        rx_data  <= {rx_shift, mosi_s};
                        rx_valid <= 1'b1;
                    end
                    if (cs_rise) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                        bit_cnt <= '0;
                    end else if (sample_edge) begin
                        rx_shift <= (SPI_TRF_BIT-1)'({rx_shift, mosi_s});
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end else if (shift_edge && (CPHA || (bit_cnt != '0))) begin
                        // CPHA=0: a shift edge before the first sample of a word is
                        // either the frame's leading edge or the previous word's
                        // trailing edge, both already covered by word start.
                        miso     <= tx_shift[SPI_TRF_BIT-1];
                        tx_shift <= {tx_shift[SPI_TRF_BIT-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase

            if (word_start) begin
                tx_underrun <= tx_ready;
                tx_ready    <= 1'b1;
                bit_cnt     <= '0;
                if (CPHA) begin
                    tx_shift <= tx_word;
                end else begin
                    miso     <= tx_word[SPI_TRF_BIT-1];
                    tx_shift <= {tx_word[SPI_TRF_BIT-2:0], 1'b0};
                end
            end

            if (tx_load && tx_ready) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule
